adder_sat_stage: RTL and testbench
==================================

Name: adder_sat_stage

Overview:
- Downstream consumer of the 4-bit signed adder stage (sum, overflowPositive, overflowNegative).
- Converts each adder result into a saturated two's-complement value and buffers it in a 2-entry valid/ready FIFO.
- Optionally counts positive and negative overflow events.
- Sits between the combinational adder and any registered consumer; it decouples adder timing from downstream back-pressure.

Parameters:
- WIDTH, 4, data width of sum and out_data (signed two's complement, WIDTH >= 2)
- CNT_W, 8, width of each overflow event counter

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream result valid
- in_ready  output  1  stage can accept a result this cycle
- sum  input  WIDTH  raw adder sum
- ovf_pos  input  1  adder positive overflow (overflowPositive)
- ovf_neg  input  1  adder negative overflow (overflowNegative)
- out_valid  output  1  head entry valid
- out_ready  input  1  downstream accepts head entry
- out_data  output  WIDTH  saturated result at head
- out_sat  output  1  head entry was saturated
- pos_cnt  output  CNT_W  positive-overflow events accepted
- neg_cnt  output  CNT_W  negative-overflow events accepted

Behaviour:
- Interface fixed: one clock, clk; reset rst_n is asynchronous, active-low. All state clears immediately when rst_n falls, regardless of clk.
- Reset values: in_ready=1, out_valid=0, out_data=0, out_sat=0, pos_cnt=0, neg_cnt=0. FIFO state=EMPTY; read/write pointers=0.
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- Saturation is applied at push:
  - ovf_neg=1: data = 1 followed by (WIDTH-1) zeros (-8 for WIDTH=4); sat=1.
  - else ovf_pos=1: data = 0 followed by (WIDTH-1) ones (+7); sat=1.
  - else: data = sum; sat=0.
  - ovf_neg wins when both flags are high (illegal input); the event counts as negative only.
- FIFO states: EMPTY, ONE, FULL.
  - EMPTY: push -> ONE.
  - ONE: push only -> FULL; pop only -> EMPTY; push and pop together -> ONE.
  - FULL: pop -> ONE; push is impossible because in_ready=0.
- in_ready = (state != FULL). It depends only on registered state; there is no combinational path from out_ready.
- out_valid = (state != EMPTY). out_data and out_sat come from the head entry.
- Latency: a result pushed at edge N is visible on out_data/out_valid after edge N (one-cycle latency). There is no fall-through within the same cycle.
- Head data stays stable while out_valid=1 && out_ready=0.
- Pointers are 1 bit and wrap 1->0. Entry order is strictly preserved.
- Counters increment on push, not on pop. They saturate at all-ones and never wrap.
- in_valid while in_ready=0: data is ignored and not counted. Upstream must hold its values.
- Reset mid-operation: buffered entries are discarded and counters are cleared.

Optional Feature:
- Macro ADDER_SAT_STAGE_CNT_EN.
- Defined: pos_cnt/neg_cnt counter logic is present, as described above.
- Undefined: no counter registers are synthesised; pos_cnt and neg_cnt are driven constant 0. Saturation and FIFO behaviour are unchanged.

Test Plan:
- Reset: hold rst_n=0 mid-stream with 2 entries buffered -> out_valid=0, in_ready=1, counters=0 immediately. First push after release appears 1 cycle later.
- Saturation: push sum=4'b0011, flags 0/0 -> out_data=4'b0011, out_sat=0. Push sum=4'b1000, ovf_pos=1 -> out_data=4'b0111, out_sat=1, pos_cnt=1. Push ovf_neg=1 -> out_data=4'b1000, neg_cnt=1.
- Back-pressure: out_ready=0, three consecutive pushes of 1,2,3 -> in_ready=0 after the 2nd, value 3 not accepted. Raise out_ready -> outputs 1 then 2 in order.
- Simultaneous: state ONE with push and pop in the same cycle -> state stays ONE, new value becomes head next cycle, no loss or duplication.
- Both flags high: push ovf_pos=1, ovf_neg=1 -> out_data=4'b1000, neg_cnt+1, pos_cnt unchanged.
- Counter saturation (macro defined, CNT_W=2): 5 positive-overflow pushes -> pos_cnt=3. With macro undefined -> pos_cnt=0 throughout.

Source files
------------

// File: rtl/adder_sat_stage.sv
// Saturating post-adder stage: clamps overflowed sums and buffers them in a 2-entry valid/ready FIFO.
// Optional overflow event counters are enabled with `define ADDER_SAT_STAGE_CNT_EN.
//
// state | meaning
// EMPTY | no entries buffered
// ONE   | one entry at head
// FULL  | two entries, upstream stalled
module adder_sat_stage #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] sum,
    input  logic             ovf_pos,
    input  logic             ovf_neg,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sat,
    output logic [CNT_W-1:0] pos_cnt,
    output logic [CNT_W-1:0] neg_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [WIDTH-1:0] mem_data_q [2];
    logic             mem_sat_q  [2];

    logic             push;
    logic             pop;
    logic [WIDTH-1:0] sat_data;
    logic             sat_flag;

    assign push = in_valid && in_ready_q;
    assign pop  = out_valid_q && out_ready;

    // Negative overflow takes priority when both flags are (illegally) set.
    always_comb begin
        sat_data = sum;
        sat_flag = 1'b0;
        if (ovf_neg) begin
            sat_data = {1'b1, {(WIDTH-1){1'b0}}};
            sat_flag = 1'b1;
        end else if (ovf_pos) begin
            sat_data = {1'b0, {(WIDTH-1){1'b1}}};
            sat_flag = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (push) state_d = ONE;
            ONE: begin
                if (push && !pop)      state_d = FULL;
                else if (pop && !push) state_d = EMPTY;
            end
            FULL:    if (pop) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    // Handshake flags are registered from the next state so in_ready never sees out_ready combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                mem_data_q[i] <= '0;
                mem_sat_q[i]  <= 1'b0;
            end
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != FULL);
            out_valid_q <= (state_d != EMPTY);
            if (push) begin
                mem_data_q[wr_ptr_q] <= sat_data;
                mem_sat_q[wr_ptr_q]  <= sat_flag;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = mem_data_q[rd_ptr_q];
    assign out_sat   = mem_sat_q[rd_ptr_q];

`ifdef ADDER_SAT_STAGE_CNT_EN
    logic [CNT_W-1:0] pos_cnt_q;
    logic [CNT_W-1:0] neg_cnt_q;

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_cnt_q <= '0;
            neg_cnt_q <= '0;
        end else if (push) begin
            if (ovf_neg) begin
                if (neg_cnt_q != {CNT_W{1'b1}}) neg_cnt_q <= neg_cnt_q + 1'b1;
            end else if (ovf_pos) begin
                if (pos_cnt_q != {CNT_W{1'b1}}) pos_cnt_q <= pos_cnt_q + 1'b1;
            end
        end
    end

    assign pos_cnt = pos_cnt_q;
    assign neg_cnt = neg_cnt_q;
`else
    assign pos_cnt = '0;
    assign neg_cnt = '0;
`endif

endmodule

// File: tb/tb_adder_sat_stage.sv
// Directed self-checking bench for adder_sat_stage (WIDTH=4, CNT_W=2).
module tb_adder_sat_stage;

    localparam int WIDTH = 4;
    localparam int CNT_W = 2;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] sum;
    logic             ovf_pos;
    logic             ovf_neg;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_sat;
    logic [CNT_W-1:0] pos_cnt;
    logic [CNT_W-1:0] neg_cnt;

    int n_total;
    int n_pass;

    adder_sat_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sum      (sum),
        .ovf_pos  (ovf_pos),
        .ovf_neg  (ovf_neg),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_sat  (out_sat),
        .pos_cnt  (pos_cnt),
        .neg_cnt  (neg_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [3:0] s;
        logic       op;
        logic       on;
        logic       ordy;
        logic       ev;
        logic [3:0] ed;
        logic       es;
        logic       eir;
        int         ep;
        int         en;
    } vec_t;

    vec_t tbl [23];

    function automatic vec_t mk(input logic iv, input logic [3:0] s, input logic op, input logic on,
                                input logic ordy, input logic ev, input logic [3:0] ed, input logic es,
                                input logic eir, input int ep, input int en);
        vec_t v;
        v.iv = iv; v.s = s; v.op = op; v.on = on; v.ordy = ordy;
        v.ev = ev; v.ed = ed; v.es = es; v.eir = eir; v.ep = ep; v.en = en;
        return v;
    endfunction

    function automatic int cnt_exp(input int raw);
`ifdef ADDER_SAT_STAGE_CNT_EN
        return raw;
`else
        return 0 * raw;
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step(input logic iv, input logic [3:0] s, input logic op, input logic on, input logic ordy);
        in_valid  = iv;
        sum       = s;
        ovf_pos   = op;
        ovf_neg   = on;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_total   = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        sum       = '0;
        ovf_pos   = 1'b0;
        ovf_neg   = 1'b0;
        out_ready = 1'b0;

        // iv  sum    op    on    ordy | ev  data   sat   ir    pos neg
        tbl[0]  = mk(1, 4'd3, 0, 0, 0,   1, 4'd3, 0, 1, 0, 0);
        tbl[1]  = mk(0, 4'd0, 0, 0, 1,   0, 4'd0, 0, 1, 0, 0);
        tbl[2]  = mk(1, 4'd8, 1, 0, 0,   1, 4'd7, 1, 1, 1, 0);
        tbl[3]  = mk(1, 4'd0, 0, 1, 1,   1, 4'd8, 1, 1, 1, 1);
        tbl[4]  = mk(1, 4'd5, 1, 1, 1,   1, 4'd8, 1, 1, 1, 2);
        tbl[5]  = mk(0, 4'd0, 0, 0, 1,   0, 4'd0, 0, 1, 1, 2);
        tbl[6]  = mk(1, 4'd1, 0, 0, 0,   1, 4'd1, 0, 1, 1, 2);
        tbl[7]  = mk(1, 4'd2, 0, 0, 0,   1, 4'd1, 0, 0, 1, 2);
        tbl[8]  = mk(1, 4'd3, 0, 0, 0,   1, 4'd1, 0, 0, 1, 2);
        tbl[9]  = mk(0, 4'd0, 0, 0, 1,   1, 4'd2, 0, 1, 1, 2);
        tbl[10] = mk(0, 4'd0, 0, 0, 1,   0, 4'd0, 0, 1, 1, 2);
        tbl[11] = mk(1, 4'd4, 0, 0, 0,   1, 4'd4, 0, 1, 1, 2);
        tbl[12] = mk(1, 4'd5, 0, 0, 0,   1, 4'd4, 0, 0, 1, 2);
        tbl[13] = mk(1, 4'd6, 1, 0, 1,   1, 4'd5, 0, 1, 1, 2);
        tbl[14] = mk(1, 4'd6, 0, 0, 1,   1, 4'd6, 0, 1, 1, 2);
        tbl[15] = mk(0, 4'd0, 0, 0, 1,   0, 4'd0, 0, 1, 1, 2);
        tbl[16] = mk(1, 4'd0, 1, 0, 1,   1, 4'd7, 1, 1, 2, 2);
        tbl[17] = mk(1, 4'd0, 1, 0, 1,   1, 4'd7, 1, 1, 3, 2);
        tbl[18] = mk(1, 4'd0, 1, 0, 1,   1, 4'd7, 1, 1, 3, 2);
        tbl[19] = mk(1, 4'd0, 1, 0, 1,   1, 4'd7, 1, 1, 3, 2);
        tbl[20] = mk(1, 4'd9, 0, 1, 1,   1, 4'd8, 1, 1, 3, 3);
        tbl[21] = mk(1, 4'd9, 0, 1, 1,   1, 4'd8, 1, 1, 3, 3);
        tbl[22] = mk(0, 4'd0, 0, 0, 1,   0, 4'd0, 0, 1, 3, 3);

        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready",  int'(in_ready), 1);
        chk("rst_out_data",  int'(out_data), 0);
        chk("rst_out_sat",   int'(out_sat), 0);
        chk("rst_pos_cnt",   int'(pos_cnt), 0);
        chk("rst_neg_cnt",   int'(neg_cnt), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 23; i++) begin
            step(tbl[i].iv, tbl[i].s, tbl[i].op, tbl[i].on, tbl[i].ordy);
            chk($sformatf("v%0d_out_valid", i), int'(out_valid), int'(tbl[i].ev));
            chk($sformatf("v%0d_in_ready", i),  int'(in_ready),  int'(tbl[i].eir));
            chk($sformatf("v%0d_pos_cnt", i),   int'(pos_cnt),   cnt_exp(tbl[i].ep));
            chk($sformatf("v%0d_neg_cnt", i),   int'(neg_cnt),   cnt_exp(tbl[i].en));
            if (tbl[i].ev) begin
                chk($sformatf("v%0d_out_data", i), int'(out_data), int'(tbl[i].ed));
                chk($sformatf("v%0d_out_sat", i),  int'(out_sat),  int'(tbl[i].es));
            end
        end

        // Fill the FIFO, then reset asynchronously between clock edges.
        step(1, 4'd1, 0, 1, 0);
        step(1, 4'd2, 1, 0, 0);
        chk("pre_rst_in_ready", int'(in_ready), 0);
        chk("pre_rst_head",     int'(out_data), 8);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", int'(out_valid), 0);
        chk("async_rst_in_ready",  int'(in_ready), 1);
        chk("async_rst_pos_cnt",   int'(pos_cnt), 0);
        chk("async_rst_neg_cnt",   int'(neg_cnt), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        in_valid  = 1'b1;
        sum       = 4'd2;
        ovf_pos   = 1'b0;
        ovf_neg   = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("post_rst_no_fallthrough", int'(out_valid), 0);
        @(posedge clk);
        #1;
        chk("post_rst_out_valid", int'(out_valid), 1);
        chk("post_rst_out_data",  int'(out_data), 2);
        chk("post_rst_pos_cnt",   int'(pos_cnt), 0);
        step(0, 4'd0, 0, 0, 1);
        chk("post_rst_drain", int'(out_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
